// File: rtl/uart_rx_byte.sv
// UART receive front end: synchronises rx_in, oversamples 8N1 frames (8E1 when
// UART_RX_PARITY_EN is defined) and presents each good byte with a RECEIVE_END strobe.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic       rx_in,
  output logic [7:0] rxd,
  output logic       RECEIVE_END,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          clk_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             sh;
  logic                   rs;
`ifdef UART_RX_PARITY_EN
  logic                   par_err;
`endif

  assign rs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge iCLK) begin
    if (!RST_n) begin
      sync_q      <= '1;
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      rxd         <= '0;
      RECEIVE_END <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_in};
      RECEIVE_END <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        S_IDLE: if (!rs) begin
          state   <= S_START;
          clk_cnt <= '0;
          rx_busy <= 1'b1;
        end
        // Half-bit check re-centres sampling on every start edge and rejects glitches.
        S_START: if (clk_cnt == HALF) begin
          clk_cnt <= '0;
          if (!rs) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end else begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end else clk_cnt <= clk_cnt + CW'(1);
        S_DATA: if (clk_cnt == LAST) begin
          clk_cnt <= '0;
          sh      <= {rs, sh[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= S_PARITY;
`else
          if (bit_idx == 3'd7) state <= S_STOP;
`endif
        end else clk_cnt <= clk_cnt + CW'(1);
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (clk_cnt == LAST) begin
          clk_cnt <= '0;
          par_err <= ^{sh, rs};
          state   <= S_STOP;
        end else clk_cnt <= clk_cnt + CW'(1);
`endif
        S_STOP: if (clk_cnt == LAST) begin
          clk_cnt <= '0;
          if (rs) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (par_err) frame_err <= 1'b1;
            else begin
              rxd         <= sh;
              RECEIVE_END <= 1'b1;
            end
`else
            rxd         <= sh;
            RECEIVE_END <= 1'b1;
`endif
          end else begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end
        end else clk_cnt <= clk_cnt + CW'(1);
        // Line held low: wait for it to return high before hunting for a start bit.
        S_BREAK: if (rs) begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
